// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants and receiver state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module  : uart_sync2
// Brief   : Two-flop synchronizer for a single asynchronous bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver, mid-bit sampling, 1-cycle valid/error pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      rx_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] c_CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic [2:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_busy;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // r_busy is updated alongside every state transition so it always mirrors r_state != IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_CNT_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_CNT_BIT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A line held low must return high before a new start bit can be seen.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign rx_busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx driven by a bit-accurate 8N1 line model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed events
    logic [7:0] got_q[$];
    int         got_idx         = 0;
    int         ferr_cnt        = 0;
    int         ferr_base       = 0;
    int         both_high       = 0;
    int         bad_data_change = 0;
    int         last_valid_cyc  = 0;
    int         vcount          = 0;
    int         burst_base      = 0;
    logic       burst_on        = 1'b0;
    int         busy_low        = 0;
    logic [7:0] prev_data;
    logic       rst_at_edge     = 1'b0;

    // Reference model state
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;
    int         t_fall   = 0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            got_q.push_back(data);
            last_valid_cyc = cyc;
            vcount++;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (data_valid === 1'b1 && frame_err === 1'b1) both_high++;
        if (rst_at_edge && data_valid !== 1'b1 && data !== prev_data) bad_data_change++;
        prev_data = data;
        if (burst_on && (vcount - burst_base) >= 1 && (vcount - burst_base) < 3 && rx_busy === 1'b0)
            busy_low++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Drives one frame and records what an ideal 8N1 receiver would report for it.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx     = 1'b0;
        t_fall = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        if (stop) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, got_q.size() - got_idx, exp_q.size());
        for (int i = 0; i < exp_q.size() && (got_idx + i) < got_q.size(); i++)
            chk({tag, "_byte"}, got_q[got_idx + i], exp_q[i]);
        got_idx = got_q.size();
        exp_q.delete();
        chk({tag, "_ferr"}, ferr_cnt - ferr_base, exp_ferr);
        ferr_base = ferr_cnt;
        exp_ferr  = 0;
        chk({tag, "_data"}, data, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       stop;
        int         lat;

        // Reset with a noisy line
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = 1'($urandom_range(0, 1));
            chk("rst_outputs", {data, data_valid, frame_err, rx_busy}, 32'h0);
        end
        @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b1;
        exp_data = 8'h00;
        repeat (40) @(negedge clk);
        check_rx("post_rst");
        chk("post_rst_busy", rx_busy, 1'b0);

        // Single byte with latency measurement
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        lat = last_valid_cyc - t_fall;
        chk("latency_154_155", (lat >= 154 && lat <= 155), 1'b1);
        check_rx("a5");

        // Back-to-back frames, no idle gap
        burst_base = vcount;
        burst_on   = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);
        burst_on = 1'b0;
        check_rx("b2b");
        chk("b2b_busy_gap", (busy_low > 0 && busy_low <= 2 * CPB), 1'b1);

        // Short low glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", rx_busy, 1'b1);
        rx = 1'b1;
        idle_bits(3);
        check_rx("glitch");
        chk("glitch_idle", rx_busy, 1'b0);

        // Bad stop bit followed by a long break
        send_frame(8'h55, 1'b0);
        for (int i = 0; i < 40; i++) drive_bit(1'b0);
        chk("break_busy", rx_busy, 1'b1);
        check_rx("break");
        idle_bits(2);
        chk("break_release", rx_busy, 1'b0);
        send_frame(8'h81, 1'b1);
        idle_bits(2);
        check_rx("after_break");

        // Reset in the middle of a frame
        b = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_outputs", {data, data_valid, frame_err, rx_busy}, 32'h0);
        rst_n    = 1'b1;
        exp_data = 8'h00;
        idle_bits(2);
        check_rx("midrst");
        send_frame(8'h12, 1'b1);
        idle_bits(2);
        check_rx("after_midrst");

        // Random frames with occasional framing errors and random gaps
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            idle_bits(stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3)));
        end
        idle_bits(2);
        check_rx("random");

        chk("never_both_pulses", both_high, 0);
        chk("data_held_between", bad_data_change, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
